// File: rtl/cache_pipe_stage.sv
// cache_pipe_stage: elastic valid/ready stage between the tag/compare and
// data/writeback cache pipeline stages. Carries read line, write line,
// address and a metadata vector. With SKID=1 a 2-entry skid buffer keeps
// in_ready registered; with SKID=0 a single register is used and in_ready
// is combinational. Also provides flush and a saturating stall counter.
module cache_pipe_stage #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int META_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [META_W-1:0] in_meta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [DATA_W-1:0] out_wdata,
  output logic [ADDR_W-1:0] out_addr,
  output logic [META_W-1:0] out_meta,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // One entry is the whole payload packed as {rdata, wdata, addr, meta}.
  localparam int ENT_W = 2 * DATA_W + ADDR_W + META_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_r;
  logic [ENT_W-1:0]   main_r;
  logic [ENT_W-1:0]   skid_r;
  logic               out_valid_r;
  logic               in_ready_r;
  logic [1:0]         occ_r;
  logic [CNT_W-1:0]   stall_r;

  logic [ENT_W-1:0]   in_ent_s;
  logic               in_ready_s;
  logic               acc_in_s;
  logic               acc_out_s;

  // Pack the incoming payload and derive ready and the two handshake strobes.
  always_comb begin
    in_ent_s = {in_rdata, in_wdata, in_addr, in_meta};
    if (SKID != 0) begin
      in_ready_s = in_ready_r;
    end else begin
      in_ready_s = !out_valid_r || out_ready;
    end
    acc_in_s  = in_valid && in_ready_s;
    acc_out_s = out_valid_r && out_ready;
  end

  // Stage FSM: main register feeds the outputs, skid register absorbs the
  // entry that arrives while the downstream is stalled (SKID=1 only).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      occ_r       <= 2'd0;
      main_r      <= {ENT_W{1'b0}};
      skid_r      <= {ENT_W{1'b0}};
    end else if (flush) begin
      // Payload registers keep stale contents; they are hidden by out_valid=0.
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      occ_r       <= 2'd0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_in_s) begin
            state_r     <= ST_ONE;
            main_r      <= in_ent_s;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
            occ_r       <= 2'd1;
          end
        end
        ST_ONE: begin
          if (acc_in_s && acc_out_s) begin
            // Old entry leaves while the new one takes its place.
            main_r <= in_ent_s;
          end else if (acc_in_s) begin
            if (SKID != 0) begin
              state_r    <= ST_FULL;
              skid_r     <= in_ent_s;
              in_ready_r <= 1'b0;
              occ_r      <= 2'd2;
            end else begin
              // Unreachable with SKID=0: accepting while ONE implies out_ready.
              main_r <= in_ent_s;
            end
          end else if (acc_out_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occ_r       <= 2'd0;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_r    <= ST_ONE;
            main_r     <= skid_r;
            in_ready_r <= 1'b1;
            occ_r      <= 2'd1;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          occ_r       <= 2'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles where the downstream stalls a valid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= {CNT_W{1'b0}};
    end else if (out_valid_r && !out_ready && (stall_r != CNT_MAX)) begin
      stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_r <= stall_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign occupancy = occ_r;
  assign stall_cnt = stall_r;
  assign out_rdata = main_r[ENT_W-1 -: DATA_W];
  assign out_wdata = main_r[ENT_W-DATA_W-1 -: DATA_W];
  assign out_addr  = main_r[META_W +: ADDR_W];
  assign out_meta  = main_r[META_W-1:0];

endmodule
